ram_bus_master: RTL and testbench

- Initiator for the single-port synchronous SRAM with shared bidirectional data bus (cs/we/oe interface).
- Converts a valid/ready request stream (read or write) into correctly sequenced chip-select, write-enable and output-enable cycles.
- Drives the shared data bus only during writes; releases it otherwise.
- Captures read data and returns it on a response channel with backpressure.

---
 rtl/ram_bus_master.sv | 164 ++++++++++++++++
 tb/tb_ram_bus_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// ram_bus_master
//   Initiator for a single-port synchronous SRAM that shares one bidirectional
//   data bus (cs/we/oe interface). Turns a valid/ready request stream into
//   sequenced chip-select / write-enable / output-enable cycles. Write data is
//   driven onto the bus only while writing. Read data is captured and returned
//   on a response channel that supports backpressure.
//
//   Parameters
//     DATA_WIDTH  width of the memory data bus and of request/response data
//     ADDR_WIDTH  width of the memory address
//
//   Ports
//     clk, rst           clock; synchronous active-high reset
//     req_valid/ready    request handshake (req_ready = idle and not in reset)
//     req_we             1 = write, 0 = read
//     req_addr/wdata     request payload, latched at acceptance
//     wr_ack             high in the cycle the memory write commits
//     rsp_valid/ready    read response handshake
//     rsp_rdata          read data, held stable while rsp_valid is high
//     mem_address        address to the memory (holds last latched address)
//     mem_data           shared data bus (inout)
//     mem_cs/we/oe       memory chip select / write enable / output enable
//
//   Optional build macro RAM_BUS_MASTER_STATS_EN adds two saturating 16-bit
//   counters: wr_count (WR cycles) and rd_count (completed read responses).
module ram_bus_master #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  wr_ack,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
`ifdef RAM_BUS_MASTER_STATS_EN
    ,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RSP     = 3'd4
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  accept;
    logic                  drive_bus;

    // The direction of the request is captured by the state chosen at
    // acceptance, so no separate we register is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // Memory output register was loaded at the end of RD_ADDR, so the
            // bus carries valid read data throughout RD_DATA.
            if (state_q == RD_DATA) begin
                rdata_q <= mem_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        drive_bus = 1'b0;
        wr_ack    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = !rst;
                accept    = req_valid && !rst;
                if (accept) begin
                    state_d = req_we ? WR : RD_ADDR;
                end
            end
            WR: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                drive_bus = 1'b1;
                wr_ack    = 1'b1;
                state_d   = IDLE;
            end
            RD_ADDR: begin
                mem_cs  = 1'b1;
                mem_oe  = 1'b1;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                mem_cs  = 1'b1;
                mem_oe  = 1'b1;
                state_d = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_address = addr_q;
    assign rsp_rdata   = rdata_q;
    assign mem_data    = drive_bus ? wdata_q : 'z;

`ifdef RAM_BUS_MASTER_STATS_EN
    logic [15:0] wr_count_q;
    logic [15:0] rd_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            if (state_q == WR && wr_count_q != '1) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (state_q == RSP && rsp_ready && rd_count_q != '1) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master
//   Directed bench for ram_bus_master with an 8-bit address and a behavioural
//   synchronous SRAM on the shared bus. Read expectations go through a
//   scoreboard queue: pushed at request acceptance, popped at the response
//   handshake. Outputs are sampled on the falling edge; inputs change there.
module tb_ram_bus_master;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          wr_ack;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_address;
    wire  [DW-1:0] mem_data;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;
`ifdef RAM_BUS_MASTER_STATS_EN
    logic [15:0]   wr_count;
    logic [15:0]   rd_count;
`endif

    ram_bus_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .wr_ack     (wr_ack),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_oe     (mem_oe)
`ifdef RAM_BUS_MASTER_STATS_EN
        ,
        .wr_count   (wr_count),
        .rd_count   (rd_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: write commits on cs&&we; output register loads on a
    // cs&&!we cycle and is driven onto the bus while cs&&oe&&!we.
    logic [DW-1:0] sram [256];
    logic [DW-1:0] sram_dout;

    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            sram[mem_address] <= mem_data;
        end else if (mem_cs && !mem_we) begin
            sram_dout <= sram[mem_address];
        end
    end

    assign mem_data = (mem_cs && mem_oe && !mem_we) ? sram_dout : 'z;

    int unsigned   cyc = 0;
    always @(posedge clk) cyc++;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_mem [256];
    logic [DW-1:0] sb [$];
    int unsigned   acc_cyc [3];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns at a falling edge where req_valid && req_ready, i.e. the
    // request is accepted on the next rising edge.
    task automatic wait_accept();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input bit keep_valid, output int unsigned acc);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        wait_accept();
        acc = cyc;
        exp_mem[addr] = data;
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
        check("wr_ack",      {63'd0, wr_ack}, 64'd1);
        check("wr_cs",       {63'd0, mem_cs}, 64'd1);
        check("wr_we",       {63'd0, mem_we}, 64'd1);
        check("wr_oe",       {63'd0, mem_oe}, 64'd0);
        check("wr_addr",     {56'd0, mem_address}, {56'd0, addr});
        check("wr_bus",      mem_data, data);
        check("wr_ready",    {63'd0, req_ready}, 64'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int hold);
        logic [DW-1:0] held;
        logic [DW-1:0] exp;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        rsp_ready = (hold == 0);
        wait_accept();
        sb.push_back(exp_mem[addr]);
        @(negedge clk);
        req_valid = 1'b0;
        check("rda_cs",    {63'd0, mem_cs}, 64'd1);
        check("rda_oe",    {63'd0, mem_oe}, 64'd1);
        check("rda_we",    {63'd0, mem_we}, 64'd0);
        check("rda_addr",  {56'd0, mem_address}, {56'd0, addr});
        check("rda_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        check("rdd_oe",    {63'd0, mem_oe}, 64'd1);
        check("rdd_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("rsp_ctrl",  {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
        check("rsp_ready_out", {63'd0, req_ready}, 64'd0);
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid",  {63'd0, rsp_valid}, 64'd1);
            check("bp_stable", rsp_rdata, held);
            check("bp_ctrl",   {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
            check("bp_ready",  {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            check("rsp_rdata", rsp_rdata, exp);
        end
        @(negedge clk);
        check("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("post_rsp_ready", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        int unsigned acc;
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        logic [DW-1:0] d [3];
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h05;
        req_wdata = 64'h1111_2222_3333_4444;
        rsp_ready = 1'b1;

        // Reset held two cycles with a request pending.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ready", {63'd0, req_ready}, 64'd0);
            check("rst_ctrl",  {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
            check("rst_ack",   {63'd0, wr_ack}, 64'd0);
            check("rst_valid", {63'd0, rsp_valid}, 64'd0);
            check("rst_addr",  {56'd0, mem_address}, 64'd0);
            check("rst_rdata", rsp_rdata, 64'd0);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {63'd0, req_ready}, 64'd1);
        check("post_rst_ctrl",  {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
        check("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);

        // Write then read.
        do_write(8'h05, 64'hDEAD_BEEF_0123_4567, 1'b0, acc);
        @(negedge clk);
        check("idle_addr_hold", {56'd0, mem_address}, 64'h05);
        do_read(8'h05, 0);

        // Back-to-back writes with req_valid held.
        d[0] = {$urandom, $urandom};
        d[1] = {$urandom, $urandom};
        d[2] = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            do_write(8'h10 + 8'(i), d[i], i != 2, acc);
            acc_cyc[i] = acc;
        end
        check("b2b_gap0", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
        check("b2b_gap1", 64'(acc_cyc[2] - acc_cyc[1]), 64'd2);
        for (int i = 0; i < 3; i++) begin
            do_read(8'h10 + 8'(i), 0);
        end

        // Response backpressure.
        do_read(8'h05, 4);

        // Reset during RD_DATA discards the read.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h05;
        wait_accept();
        sb.push_back(exp_mem[8'h05]);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_rdd", {63'd0, mem_oe}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        check("abort_ctrl",  {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
        check("abort_valid", {63'd0, rsp_valid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
            check("abort_ready",  {63'd0, req_ready}, 64'd1);
        end
        do_read(8'h05, 0);

`ifdef RAM_BUS_MASTER_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("stat_rst_wr", {48'd0, wr_count}, 64'd0);
        check("stat_rst_rd", {48'd0, rd_count}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            do_write(8'h20 + 8'(i), 64'(i + 100), 1'b0, acc);
        end
        do_read(8'h20, 0);
        do_read(8'h22, 0);
        check("stat_wr3", {48'd0, wr_count}, 64'd3);
        check("stat_rd2", {48'd0, rd_count}, 64'd2);
        force dut.wr_count_q = 16'hFFFE;
        #1;
        release dut.wr_count_q;
        for (int i = 0; i < 3; i++) begin
            do_write(8'h30 + 8'(i), 64'(i), 1'b0, acc);
        end
        @(negedge clk);
        check("stat_sat", {48'd0, wr_count}, 64'hFFFF);
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
